// File: rtl/pcap_clock_adj.sv
// Adjustable PCAP time-of-day generator: seconds/nanoseconds with a fractional-ns
// increment, absolute set, one-shot signed step, rate tuning, PPS and per-port capture.
module pcap_clock_adj #(
  parameter int PERIOD_NS  = 4,
  parameter int PERIOD_FNS = 0,
  parameter int FNS_W      = 16,
  parameter int ADJ_W      = 20,
  parameter int NUM_CAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [31:0]           set_sec,
  input  logic [29:0]           set_nsec,
  output logic                  set_err,
  input  logic                  adj_valid,
  input  logic [ADJ_W-1:0]      adj_ns,
  input  logic                  inc_valid,
  input  logic [7:0]            inc_ns,
  input  logic [FNS_W-1:0]      inc_fns,
  output logic [31:0]           sec,
  output logic [31:0]           nsec,
  output logic                  pps,
  input  logic [NUM_CAP-1:0]    cap_strobe,
  output logic [NUM_CAP-1:0]    cap_valid,
  output logic [32*NUM_CAP-1:0] cap_sec,
  output logic [32*NUM_CAP-1:0] cap_nsec
);

  localparam logic signed [32:0] NS_PER_SEC = 33'sd1_000_000_000;

  function automatic logic signed [32:0] sext_adj(input logic [ADJ_W-1:0] a);
    return {{(33-ADJ_W){a[ADJ_W-1]}}, a};
  endfunction

  // One correction is enough: |adj| < 2^29 keeps the raw sum within one second of range.
  function automatic logic [29:0] wrap_ns(input logic signed [32:0] raw);
    logic signed [32:0] fixed;
    fixed = raw;
    if (raw >= NS_PER_SEC)
      fixed = raw - NS_PER_SEC;
    else if (raw < 33'sd0)
      fixed = raw + NS_PER_SEC;
    return fixed[29:0];
  endfunction

  logic [31:0]           sec_q, sec_d;
  logic [29:0]           ns_q, ns_d;
  logic [FNS_W-1:0]      frac_q, frac_d;
  logic [7:0]            inc_ns_q, inc_ns_d;
  logic [FNS_W-1:0]      inc_fns_q, inc_fns_d;
  logic                  pps_q, pps_d;
  logic                  set_err_q, set_err_d;
  logic [NUM_CAP-1:0]    cap_valid_q, cap_valid_d;
  logic [32*NUM_CAP-1:0] cap_sec_q, cap_sec_d;
  logic [32*NUM_CAP-1:0] cap_nsec_q, cap_nsec_d;

  logic [FNS_W:0]        frac_sum;
  logic signed [32:0]    ns_sum;
  logic                  set_ok;
  logic                  carry_fwd;
  logic                  borrow;

  // Stage boundary: combinational next-time from current registers and strobes
  assign frac_sum  = {1'b0, frac_q} + {1'b0, inc_fns_q};
  assign set_ok    = set_valid && (set_nsec < 30'd1_000_000_000);
  assign ns_sum    = $signed({3'b000, ns_q})
                   + $signed({25'd0, inc_ns_q})
                   + $signed({32'd0, frac_sum[FNS_W]})
                   + (adj_valid ? sext_adj(adj_ns) : 33'sd0);
  assign carry_fwd = (ns_sum >= NS_PER_SEC);
  assign borrow    = (ns_sum < 33'sd0);

  always_comb begin
    sec_d     = sec_q;
    ns_d      = ns_q;
    frac_d    = frac_q;
    pps_d     = 1'b0;
    set_err_d = 1'b0;
    inc_ns_d  = inc_ns_q;
    inc_fns_d = inc_fns_q;

    if (inc_valid) begin
      inc_ns_d  = inc_ns;
      inc_fns_d = inc_fns;
    end

    if (set_ok) begin
      sec_d  = set_sec;
      ns_d   = set_nsec;
      frac_d = '0;
    end else begin
      set_err_d = set_valid;
      frac_d    = frac_sum[FNS_W-1:0];
      ns_d      = wrap_ns(ns_sum);
      if (carry_fwd) begin
        sec_d = sec_q + 32'd1;
        pps_d = 1'b1;
      end else if (borrow) begin
        sec_d = sec_q - 32'd1;
      end
    end
  end

  // Captures take the pre-edge outputs, independent of what the time update does.
  always_comb begin
    cap_valid_d = cap_strobe;
    cap_sec_d   = cap_sec_q;
    cap_nsec_d  = cap_nsec_q;
    for (int i = 0; i < NUM_CAP; i++) begin
      if (cap_strobe[i]) begin
        cap_sec_d[32*i +: 32]  = sec_q;
        cap_nsec_d[32*i +: 32] = {2'b00, ns_q};
      end
    end
  end

  // Stage boundary: architectural state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= '0;
      ns_q        <= '0;
      frac_q      <= '0;
      inc_ns_q    <= 8'(PERIOD_NS);
      inc_fns_q   <= FNS_W'(PERIOD_FNS);
      pps_q       <= 1'b0;
      set_err_q   <= 1'b0;
      cap_valid_q <= '0;
      cap_sec_q   <= '0;
      cap_nsec_q  <= '0;
    end else begin
      sec_q       <= sec_d;
      ns_q        <= ns_d;
      frac_q      <= frac_d;
      inc_ns_q    <= inc_ns_d;
      inc_fns_q   <= inc_fns_d;
      pps_q       <= pps_d;
      set_err_q   <= set_err_d;
      cap_valid_q <= cap_valid_d;
      cap_sec_q   <= cap_sec_d;
      cap_nsec_q  <= cap_nsec_d;
    end
  end

  assign sec       = sec_q;
  assign nsec      = {2'b00, ns_q};
  assign pps       = pps_q;
  assign set_err   = set_err_q;
  assign cap_valid = cap_valid_q;
  assign cap_sec   = cap_sec_q;
  assign cap_nsec  = cap_nsec_q;

endmodule

// File: tb/tb_pcap_clock_adj.sv
// Bench for pcap_clock_adj: reference model in fixed-point ns, vector table,
// directed multi-cycle sequences and randomized traffic.
module tb_pcap_clock_adj;

  localparam int PERIOD_NS  = 4;
  localparam int PERIOD_FNS = 0;
  localparam int FNS_W      = 16;
  localparam int ADJ_W      = 20;
  localparam int NUM_CAP    = 2;
  localparam longint ONE_SEC = longint'(1_000_000_000) <<< FNS_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  set_valid = 1'b0;
  logic [31:0]           set_sec = '0;
  logic [29:0]           set_nsec = '0;
  logic                  set_err;
  logic                  adj_valid = 1'b0;
  logic [ADJ_W-1:0]      adj_ns = '0;
  logic                  inc_valid = 1'b0;
  logic [7:0]            inc_ns = '0;
  logic [FNS_W-1:0]      inc_fns = '0;
  logic [31:0]           sec;
  logic [31:0]           nsec;
  logic                  pps;
  logic [NUM_CAP-1:0]    cap_strobe = '0;
  logic [NUM_CAP-1:0]    cap_valid;
  logic [32*NUM_CAP-1:0] cap_sec;
  logic [32*NUM_CAP-1:0] cap_nsec;

  pcap_clock_adj #(
    .PERIOD_NS(PERIOD_NS), .PERIOD_FNS(PERIOD_FNS), .FNS_W(FNS_W),
    .ADJ_W(ADJ_W), .NUM_CAP(NUM_CAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .set_valid(set_valid), .set_sec(set_sec), .set_nsec(set_nsec), .set_err(set_err),
    .adj_valid(adj_valid), .adj_ns(adj_ns),
    .inc_valid(inc_valid), .inc_ns(inc_ns), .inc_fns(inc_fns),
    .sec(sec), .nsec(nsec), .pps(pps),
    .cap_strobe(cap_strobe), .cap_valid(cap_valid), .cap_sec(cap_sec), .cap_nsec(cap_nsec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time held as one fixed-point count of 2^-FNS_W ns within the second.
  logic [31:0]        m_sec;
  longint             m_t;
  longint             m_inc;
  logic               m_pps;
  logic               m_err;
  logic [NUM_CAP-1:0] m_cap_v;
  logic [31:0]        m_cap_sec [NUM_CAP];
  logic [31:0]        m_cap_ns  [NUM_CAP];

  task automatic model_reset();
    m_sec   = '0;
    m_t     = 0;
    m_inc   = (longint'(PERIOD_NS) <<< FNS_W) + longint'(PERIOD_FNS);
    m_pps   = 1'b0;
    m_err   = 1'b0;
    m_cap_v = '0;
    for (int i = 0; i < NUM_CAP; i++) begin
      m_cap_sec[i] = '0;
      m_cap_ns[i]  = '0;
    end
  endtask

  task automatic model_edge();
    longint a;
    m_cap_v = cap_strobe;
    for (int i = 0; i < NUM_CAP; i++) begin
      if (cap_strobe[i]) begin
        m_cap_sec[i] = m_sec;
        m_cap_ns[i]  = 32'(m_t >>> FNS_W);
      end
    end
    m_pps = 1'b0;
    m_err = 1'b0;
    if (set_valid && set_nsec < 30'd1_000_000_000) begin
      m_sec = set_sec;
      m_t   = longint'(set_nsec) <<< FNS_W;
    end else begin
      m_err = set_valid;
      a = longint'(adj_ns);
      if (adj_ns[ADJ_W-1]) a = a - (longint'(1) <<< ADJ_W);
      m_t = m_t + m_inc + (adj_valid ? (a <<< FNS_W) : 0);
      if (m_t >= ONE_SEC) begin
        m_t   = m_t - ONE_SEC;
        m_sec = m_sec + 32'd1;
        m_pps = 1'b1;
      end else if (m_t < 0) begin
        m_t   = m_t + ONE_SEC;
        m_sec = m_sec - 32'd1;
      end
    end
    if (inc_valid) m_inc = (longint'(inc_ns) <<< FNS_W) + longint'(inc_fns);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("sec", 64'(sec), 64'(m_sec));
    check("nsec", 64'(nsec), 64'(m_t >>> FNS_W));
    check("pps", 64'(pps), 64'(m_pps));
    check("set_err", 64'(set_err), 64'(m_err));
    check("cap_valid", 64'(cap_valid), 64'(m_cap_v));
    for (int i = 0; i < NUM_CAP; i++) begin
      check($sformatf("cap_sec[%0d]", i), 64'(cap_sec[32*i +: 32]), 64'(m_cap_sec[i]));
      check($sformatf("cap_nsec[%0d]", i), 64'(cap_nsec[32*i +: 32]), 64'(m_cap_ns[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    set_valid  = 1'b0;
    adj_valid  = 1'b0;
    inc_valid  = 1'b0;
    cap_strobe = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sec"}, 64'(sec), 64'd0);
    check({tag, "_nsec"}, 64'(nsec), 64'd0);
    check({tag, "_pps"}, 64'(pps), 64'd0);
    check({tag, "_set_err"}, 64'(set_err), 64'd0);
    check({tag, "_cap_valid"}, 64'(cap_valid), 64'd0);
    check({tag, "_cap_sec"}, 64'(cap_sec), 64'd0);
    check({tag, "_cap_nsec"}, 64'(cap_nsec), 64'd0);
  endtask

  typedef struct {
    logic [31:0] pre_sec;
    logic [29:0] pre_ns;
    logic        set_v;
    logic [31:0] s_sec;
    logic [29:0] s_ns;
    logic        adj_v;
    int          adj;
    logic [31:0] e_sec;
    logic [31:0] e_ns;
    logic        e_pps;
    logic        e_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] rnd;
    int          r;
    longint      exp_ns;
    int          seq_ns [4];
    int          n_drift;

    vecs[0]  = '{32'd5, 30'd10, 1'b0, 32'd0, 30'd0, 1'b1, -20, 32'd4, 32'd999_999_994, 1'b0, 1'b0};
    vecs[1]  = '{32'd7, 30'd999_999_990, 1'b0, 32'd0, 30'd0, 1'b1, 7, 32'd8, 32'd1, 1'b1, 1'b0};
    vecs[2]  = '{32'd3, 30'd999_999_996, 1'b0, 32'd0, 30'd0, 1'b0, 0, 32'd4, 32'd0, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 30'd999_999_996, 1'b0, 32'd0, 30'd0, 1'b0, 0, 32'd0, 32'd0, 1'b1, 1'b0};
    vecs[4]  = '{32'd0, 30'd0, 1'b0, 32'd0, 30'd0, 1'b1, -5, 32'hFFFF_FFFF, 32'd999_999_999, 1'b0, 1'b0};
    vecs[5]  = '{32'd2, 30'd100, 1'b1, 32'd77, 30'd1_000_000_000, 1'b1, 100, 32'd2, 32'd204, 1'b0, 1'b1};
    vecs[6]  = '{32'd2, 30'd100, 1'b1, 32'd9, 30'd500, 1'b1, 100, 32'd9, 32'd500, 1'b0, 1'b0};
    vecs[7]  = '{32'd1, 30'd999_999_999, 1'b1, 32'd10, 30'd999_999_999, 1'b0, 0, 32'd10, 32'd999_999_999, 1'b0, 1'b0};
    vecs[8]  = '{32'd0, 30'd50, 1'b1, 32'd3, 30'h3FFF_FFFF, 1'b0, 0, 32'd0, 32'd54, 1'b0, 1'b1};
    vecs[9]  = '{32'd6, 30'd999_999_998, 1'b0, 32'd0, 30'd0, 1'b1, 524287, 32'd7, 32'd524_289, 1'b1, 1'b0};
    vecs[10] = '{32'd6, 30'd3, 1'b0, 32'd0, 30'd0, 1'b1, -524288, 32'd5, 32'd999_475_719, 1'b0, 1'b0};
    vecs[11] = '{32'd8, 30'd999_999_996, 1'b0, 32'd0, 30'd0, 1'b1, 0, 32'd9, 32'd0, 1'b1, 1'b0};

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free run at the default 4 ns increment
    repeat (250) step();
    check("run250_nsec", 64'(nsec), 64'd1000);
    check("run250_sec", 64'(sec), 64'd0);

    // Table: preload a time, apply one operation, compare with fixed expectations
    for (int k = 0; k < 12; k++) begin
      set_valid = 1'b1;
      set_sec   = vecs[k].pre_sec;
      set_nsec  = vecs[k].pre_ns;
      step();
      idle();
      set_valid = vecs[k].set_v;
      set_sec   = vecs[k].s_sec;
      set_nsec  = vecs[k].s_ns;
      adj_valid = vecs[k].adj_v;
      adj_ns    = vecs[k].adj[ADJ_W-1:0];
      step();
      idle();
      check($sformatf("vec%0d_sec", k), 64'(sec), 64'(vecs[k].e_sec));
      check($sformatf("vec%0d_nsec", k), 64'(nsec), 64'(vecs[k].e_ns));
      check($sformatf("vec%0d_pps", k), 64'(pps), 64'(vecs[k].e_pps));
      check($sformatf("vec%0d_err", k), 64'(set_err), 64'(vecs[k].e_err));
    end
    step();
    check("pps_one_cycle", 64'(pps), 64'd0);
    check("set_err_one_cycle", 64'(set_err), 64'd0);

    // Fractional increment 6 + 0x5555/65536 ns, loaded alongside a set to zero
    inc_valid = 1'b1; inc_ns = 8'd6; inc_fns = 16'h5555;
    set_valid = 1'b1; set_sec = 32'd0; set_nsec = 30'd0;
    step();
    idle();
    check("frac_set_nsec", 64'(nsec), 64'd0);
    seq_ns = '{6, 12, 18, 25};
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("frac_seq%0d", k), 64'(nsec), 64'(seq_ns[k]));
    end
    n_drift = 40000;
    repeat (n_drift - 4) step();
    exp_ns = (longint'(n_drift) * longint'(6 * 65536 + 'h5555)) >>> 16;
    check("frac_drift_nsec", 64'(nsec), 64'(exp_ns));

    // Zero increment freezes time; adj still applies
    inc_valid = 1'b1; inc_ns = 8'd0; inc_fns = '0;
    set_valid = 1'b1; set_sec = 32'd1; set_nsec = 30'd100;
    step();
    idle();
    repeat (5) step();
    check("freeze_nsec", 64'(nsec), 64'd100);
    check("freeze_sec", 64'(sec), 64'd1);
    adj_valid = 1'b1; adj_ns = 20'd50;
    step();
    idle();
    check("freeze_adj_nsec", 64'(nsec), 64'd150);
    inc_valid = 1'b1; inc_ns = 8'd4; inc_fns = '0;
    step();
    idle();
    check("inc_strobe_old_inc", 64'(nsec), 64'd150);
    step();
    check("inc_new_used", 64'(nsec), 64'd154);

    // Capture on channel 1 coincident with a set
    set_valid = 1'b1; set_sec = 32'd20; set_nsec = 30'd500;
    step();
    idle();
    set_valid = 1'b1; set_sec = 32'd30; set_nsec = 30'd0;
    cap_strobe = 2'b10;
    step();
    idle();
    check("cap1_valid", 64'(cap_valid), 64'b10);
    check("cap1_sec", 64'(cap_sec[63:32]), 64'd20);
    check("cap1_nsec", 64'(cap_nsec[63:32]), 64'd500);
    check("cap0_sec_untouched", 64'(cap_sec[31:0]), 64'd0);
    check("cap_set_sec", 64'(sec), 64'd30);
    step();
    check("cap_valid_drop", 64'(cap_valid), 64'd0);
    check("cap1_hold", 64'(cap_nsec[63:32]), 64'd500);
    cap_strobe = 2'b01;
    repeat (3) step();
    idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      set_valid = (r < 4);
      rnd = $urandom;
      set_sec = rnd;
      r = int'($urandom_range(0, 2));
      if (r == 0) set_nsec = 30'($urandom_range(0, 999_999_999));
      else if (r == 1) set_nsec = 30'($urandom_range(999_999_900, 999_999_999));
      else set_nsec = 30'($urandom_range(1_000_000_000, 1_073_741_823));
      adj_valid = ($urandom_range(0, 9) == 0);
      rnd = $urandom;
      adj_ns = rnd[ADJ_W-1:0];
      inc_valid = ($urandom_range(0, 49) == 0);
      inc_ns = 8'($urandom_range(0, 40));
      rnd = $urandom;
      inc_fns = rnd[FNS_W-1:0];
      rnd = $urandom;
      cap_strobe = rnd[NUM_CAP-1:0];
      step();
    end
    idle();

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    #2;
    rst_n = 1'b1;
    repeat (10) step();
    check("post_rst_nsec", 64'(nsec), 64'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
